// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, the instruction cache, the execute
// redirect path and the decode stage.
interface fetch_unit_if;
  logic [31:0] InstructionAddress;
  logic [31:0] Instruction;
  logic        InstructionReady;
  logic        RedirectValid;
  logic [31:0] RedirectAddress;
  logic        DecodeValid;
  logic [31:0] DecodeInstruction;
  logic [31:0] DecodePC;
  logic        DecodeReady;

  modport master (
    output InstructionAddress, DecodeValid, DecodeInstruction, DecodePC,
    input  Instruction, InstructionReady, RedirectValid, RedirectAddress, DecodeReady
  );

  modport slave (
    input  InstructionAddress, DecodeValid, DecodeInstruction, DecodePC,
    output Instruction, InstructionReady, RedirectValid, RedirectAddress, DecodeReady
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: ISSUE/WAIT sequencer driving the cache address from the PC,
// a FIFO of {PC, instruction} toward decode, and a pending-redirect register.
module fetch_unit #(
  parameter logic [31:0] ResetVector = 32'h0000_0000,
  parameter int unsigned Depth       = 4
) (
  input logic          Clock,
  input logic          Reset,
  fetch_unit_if.master bus
);
  localparam int unsigned    PtrW      = $clog2(Depth);
  localparam int unsigned    CntW      = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  typedef enum logic [0:0] {ST_ISSUE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [31:0]       pc_r, pc_s;
  logic [31:0]       pending_r, pending_s;
  logic              pending_valid_r, pending_valid_s;
  logic [PtrW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CntW-1:0]   count_r;
  logic              push_s, pop_s;
  logic [31:0]       redirect_target_s;
  logic [31:0]       pc_mem_r    [Depth];
  logic [31:0]       instr_mem_r [Depth];

  assign redirect_target_s = bus.RedirectAddress & ~32'h0000_0003;
  // A live redirect flushes the queue, so decode's handshake is ignored that cycle.
  assign pop_s = (count_r != CntW'(0)) && bus.DecodeReady && !bus.RedirectValid;

  always_comb begin
    state_s         = state_r;
    pc_s            = pc_r;
    pending_s       = pending_r;
    pending_valid_s = pending_valid_r;
    push_s          = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        state_s = ST_WAIT;
        if (bus.RedirectValid) begin
          pending_s       = redirect_target_s;
          pending_valid_s = 1'b1;
        end else begin
          pending_valid_s = pending_valid_r;
        end
      end
      ST_WAIT: begin
        if (bus.InstructionReady) begin
          if (bus.RedirectValid) begin
            pc_s            = redirect_target_s;
            pending_valid_s = 1'b0;
            state_s         = ST_ISSUE;
          end else if (pending_valid_r) begin
            // The returned word belongs to the abandoned path and is dropped.
            pc_s            = pending_r;
            pending_valid_s = 1'b0;
            state_s         = ST_ISSUE;
          end else if (count_r != FullCount) begin
            push_s  = 1'b1;
            pc_s    = pc_r + 32'd4;
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_WAIT;
          if (bus.RedirectValid) begin
            pending_s       = redirect_target_s;
            pending_valid_s = 1'b1;
          end else begin
            pending_valid_s = pending_valid_r;
          end
        end
      end
      default: begin
        state_s = ST_ISSUE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r         <= ST_ISSUE;
      pc_r            <= ResetVector & ~32'h0000_0003;
      pending_r       <= 32'h0000_0000;
      pending_valid_r <= 1'b0;
      wr_ptr_r        <= PtrW'(0);
      rd_ptr_r        <= PtrW'(0);
      count_r         <= CntW'(0);
    end else begin
      state_r         <= state_s;
      pc_r            <= pc_s;
      pending_r       <= pending_s;
      pending_valid_r <= pending_valid_s;
      if (bus.RedirectValid) begin
        wr_ptr_r <= PtrW'(0);
        rd_ptr_r <= PtrW'(0);
        count_r  <= CntW'(0);
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1);
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CntW'(1);
          2'b01:   count_r <= count_r - CntW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (push_s && !Reset) begin
      pc_mem_r[wr_ptr_r]    <= pc_r;
      instr_mem_r[wr_ptr_r] <= bus.Instruction;
    end
  end

  assign bus.InstructionAddress = pc_r;
  assign bus.DecodeValid        = (count_r != CntW'(0));
  assign bus.DecodePC           = pc_mem_r[rd_ptr_r];
  assign bus.DecodeInstruction  = instr_mem_r[rd_ptr_r];
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: ResetVector, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: Depth, 4, fetch-queue entries (power of two, 2..16).
REQ-003 Clock  input  1  rising-edge clock; reset Reset, synchronous, active-high; clock Clock.
REQ-004 Reset  input  1  synchronous active-high reset.
REQ-005 InstructionAddress  output  32  word address presented to the instruction cache, registered.
REQ-006 Instruction  input  32  cache read data.
REQ-007 InstructionReady  input  1  cache result valid for the address held since the previous edge.
REQ-008 RedirectValid  input  1  one-cycle pulse from execute: branch/jump/trap redirect.
REQ-009 RedirectAddress  input  32  redirect target; bits [1:0] ignored.
REQ-010 DecodeValid  output  1  queue head valid, i.e. Count != 0.
REQ-011 DecodeInstruction  output  32  queue head instruction.
REQ-012 DecodePC  output  32  queue head address.
REQ-013 DecodeReady  input  1  decode consumes head when DecodeValid && DecodeReady.

Function
REQ-014 States: ISSUE, WAIT; PC register drives InstructionAddress directly, bits [1:0] always 0.
REQ-015 ISSUE lasts exactly one cycle after any PC change; InstructionReady ignored in ISSUE (reflects the previous address); next state WAIT.
REQ-016 WAIT, InstructionReady=0: cache miss fill in flight; PC held stable; stay WAIT.
REQ-017 WAIT, InstructionReady=1, no redirect (live or pending), Count<Depth: push {PC, Instruction}; PC <= PC+4 (32-bit wrap, 32'hFFFF_FFFC -> 0); -> ISSUE.
REQ-018 WAIT, InstructionReady=1, Count==Depth: no push, PC held, stay WAIT; pop in same cycle does not enable push.
REQ-019 Peak throughput one instruction per 2 cycles on cache hits.
REQ-020 PC never changes while state is WAIT with InstructionReady=0, or in ISSUE; a cache fill never sees an address change.
REQ-021 RedirectValid flushes the queue at that edge (Count <= 0, pointers reset) regardless of state; simultaneous pop ignored.
REQ-022 RedirectValid in WAIT with InstructionReady=1: PC <= {RedirectAddress[31:2],2'b0}, no push, -> ISSUE.
REQ-023 RedirectValid otherwise: target stored in Pending register, PendingValid <= 1; later redirect overwrites Pending.
REQ-024 PendingValid in WAIT with InstructionReady=1 (and no live redirect): PC <= Pending, PendingValid <= 0, result discarded, -> ISSUE.
REQ-025 No push occurs while PendingValid=1 or RedirectValid=1.
REQ-026 Queue: circular buffer, read/write pointers log2(Depth) bits wrap modulo Depth, Count 0..Depth; push and pop in same cycle leave Count unchanged.
REQ-027 DecodeInstruction/DecodePC valid only when DecodeValid=1; contents otherwise don't-care.
REQ-028 Queue order strictly FIFO; DecodePC of consecutive entries differ by 4 unless separated by a redirect.

Reset
REQ-029 Reset: PC <= ResetVector & ~32'h3, state ISSUE, Count/pointers <= 0, PendingValid <= 0, DecodeValid=0.
REQ-030 Reset mid-fill or mid-queue discards all state; no push or pop on reset cycle; Reset dominates RedirectValid.
REQ-031 First valid InstructionAddress is ResetVector the cycle after Reset deasserts.

Verification
REQ-032 Reset, cache model always hits with Instruction=addr^32'hA5A5A5A5, DecodeReady=1 -> DecodePC 0,4,8,... one entry every 2 cycles, data matches.
REQ-033 DecodeReady=0, hits -> Count reaches Depth=4, PC holds 32'h10, state stays WAIT; DecodeReady=1 -> resumes at 32'h10, no loss/duplication.
REQ-034 Miss: InstructionReady low 10 cycles, RedirectValid to 32'h200 on cycle 4 -> InstructionAddress constant during fill; on Ready, data discarded, next address 32'h200.
REQ-035 Two redirects during one miss (32'h300 then 32'h400) -> only 32'h400 fetched; queue empty after first redirect.
REQ-036 Queue full with RedirectValid+DecodeReady same cycle -> Count=0, DecodeValid=0 next cycle, no stale entry ever presented.
REQ-037 ResetVector=32'hFFFF_FFF8, hits -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; Reset mid-miss -> InstructionAddress returns to ResetVector next cycle.
